// File: rtl/rename_map_pkg.sv
// Shared widths, tag types and the output record for the two-wide rename stage.
package rename_map_pkg;
  localparam int ARCH_REG_NUM = 32;
  localparam int ARCH_SEL     = 5;
  localparam int PHY_SEL      = 6;
  localparam int NUM_LANES    = 2;
  localparam int SMT_RD_N     = 6;

  typedef logic [ARCH_SEL-1:0]                    arch_t;
  typedef logic [PHY_SEL-1:0]                     phy_t;
  typedef logic [ARCH_REG_NUM-1:0][PHY_SEL-1:0]   map_t;

  typedef struct packed {
    logic valid;
    logic wr;
    phy_t prs1;
    phy_t prs2;
    phy_t prd;
    phy_t old_prd;
  } rn_out_t;

  // Architectural register i starts out owning physical tag i.
  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < ARCH_REG_NUM; i++) m[i] = PHY_SEL'(i);
    return m;
  endfunction
endpackage

// File: rtl/rename_map_if.sv
// Decode/free-list/commit inputs and dispatch outputs of the rename stage.
interface rename_map_if;
  import rename_map_pkg::*;

  logic  invalid1, invalid2;
  logic  wr_reg_1, wr_reg_2;
  arch_t rs1_1, rs2_1, rd_1;
  arch_t rs1_2, rs2_2, rd_2;
  phy_t  phy_dst_1, phy_dst_2;
  logic  phy_dst_valid_1, phy_dst_valid_2;
  logic  allocatable;
  logic  stall_DP;
  logic  prmiss;
  logic  com_valid_1, com_valid_2;
  arch_t com_rd_1, com_rd_2;
  phy_t  com_prd_1, com_prd_2;

  logic  rn_valid_1, rn_valid_2;
  phy_t  prs1_1, prs2_1, prs1_2, prs2_2;
  phy_t  prd_1, prd_2;
  phy_t  old_prd_1, old_prd_2;
  logic  rn_wr_1, rn_wr_2;
  logic  rn_stall;

  modport slave (
    input  invalid1, invalid2, wr_reg_1, wr_reg_2,
    input  rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2,
    input  phy_dst_1, phy_dst_2, phy_dst_valid_1, phy_dst_valid_2,
    input  allocatable, stall_DP, prmiss,
    input  com_valid_1, com_valid_2, com_rd_1, com_rd_2, com_prd_1, com_prd_2,
    output rn_valid_1, rn_valid_2, prs1_1, prs2_1, prs1_2, prs2_2,
    output prd_1, prd_2, old_prd_1, old_prd_2, rn_wr_1, rn_wr_2, rn_stall
  );

  modport master (
    output invalid1, invalid2, wr_reg_1, wr_reg_2,
    output rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2,
    output phy_dst_1, phy_dst_2, phy_dst_valid_1, phy_dst_valid_2,
    output allocatable, stall_DP, prmiss,
    output com_valid_1, com_valid_2, com_rd_1, com_rd_2, com_prd_1, com_prd_2,
    input  rn_valid_1, rn_valid_2, prs1_1, prs2_1, prs1_2, prs2_2,
    input  prd_1, prd_2, old_prd_1, old_prd_2, rn_wr_1, rn_wr_2, rn_stall
  );
endinterface

// File: rtl/rename_map_map_table.sv
// Arch->phys map flop array: RD_N combinational reads, two writes (port 2 wins),
// whole-table load, and the next-state table exported for bulk copy.
module rename_map_map_table
  import rename_map_pkg::*;
#(
  parameter int RD_N = SMT_RD_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  arch_t [RD_N-1:0] raddr,
  output phy_t  [RD_N-1:0] rdata,
  input  logic  [1:0]      we,
  input  arch_t [1:0]      waddr,
  input  phy_t  [1:0]      wdata,
  input  logic             load_en,
  input  map_t             load_map,
  output map_t             map_nxt
);
  map_t map_q, map_d;

  // Later write port applied last so it wins on an address collision.
  always_comb begin
    map_d = map_q;
    if (load_en) begin
      map_d = load_map;
    end else begin
      for (int k = 0; k < 2; k++)
        if (we[k]) map_d[waddr[k]] = wdata[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) map_q <= identity_map();
    else        map_q <= map_d;
  end

  for (genvar i = 0; i < RD_N; i++) begin : g_rd
    assign rdata[i] = map_q[raddr[i]];
  end

  assign map_nxt = map_d;
endmodule

// File: rtl/rename_map.sv
// Two-wide rename: SMT lookups with slot1->slot2 bypass, registered outputs,
// CMT tracking commits and restoring the SMT on mispredict.
module rename_map
  import rename_map_pkg::*;
(
  input logic         clk,
  input logic         reset,
  rename_map_if.slave io
);
  logic    [NUM_LANES-1:0] inv, wr, w, com_v, we_c, we_s;
  arch_t   [NUM_LANES-1:0] rs1, rs2, rd, com_rd;
  phy_t    [NUM_LANES-1:0] tag, com_prd;
  phy_t    [SMT_RD_N-1:0]  smt_rd;
  arch_t   [SMT_RD_N-1:0]  smt_ra;
  phy_t    [0:0]           cmt_rd_nc;
  map_t                    cmt_nxt, smt_nxt_nc;
  rn_out_t [NUM_LANES-1:0] out_q, out_d;
  logic                    fire, byp_rs1, byp_rs2, byp_rd;

  assign inv     = {io.invalid2,   io.invalid1};
  assign wr      = {io.wr_reg_2,   io.wr_reg_1};
  assign rs1     = {io.rs1_2,      io.rs1_1};
  assign rs2     = {io.rs2_2,      io.rs2_1};
  assign rd      = {io.rd_2,       io.rd_1};
  assign tag     = {io.phy_dst_2,  io.phy_dst_1};
  assign com_v   = {io.com_valid_2, io.com_valid_1};
  assign com_rd  = {io.com_rd_2,   io.com_rd_1};
  assign com_prd = {io.com_prd_2,  io.com_prd_1};

  // Register 0 is hardwired to tag 0, so it is never renamed or committed.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign w[l]    = ~inv[l] & wr[l] & (rd[l] != '0);
    assign we_c[l] = com_v[l] & (com_rd[l] != '0);
    assign we_s[l] = fire & w[l];
  end

  assign fire    = io.allocatable & ~io.stall_DP & ~io.prmiss;
  assign smt_ra  = {rd[1], rs2[1], rs1[1], rd[0], rs2[0], rs1[0]};
  assign byp_rs1 = w[0] & (rs1[1] == rd[0]);
  assign byp_rs2 = w[0] & (rs2[1] == rd[0]);
  assign byp_rd  = w[0] & (rd[1]  == rd[0]);

  rename_map_map_table #(.RD_N(SMT_RD_N)) u_smt (
    .clk      (clk),
    .rst_n    (reset),
    .raddr    (smt_ra),
    .rdata    (smt_rd),
    .we       (we_s),
    .waddr    (rd),
    .wdata    (tag),
    .load_en  (io.prmiss),
    .load_map (cmt_nxt),
    .map_nxt  (smt_nxt_nc)
  );

  // Restore source is the CMT's next state so same-cycle commits are included.
  rename_map_map_table #(.RD_N(1)) u_cmt (
    .clk      (clk),
    .rst_n    (reset),
    .raddr    ('0),
    .rdata    (cmt_rd_nc),
    .we       (we_c),
    .waddr    (com_rd),
    .wdata    (com_prd),
    .load_en  (1'b0),
    .load_map ('0),
    .map_nxt  (cmt_nxt)
  );

  always_comb begin
    out_d = out_q;
    if (io.prmiss) begin
      for (int l = 0; l < NUM_LANES; l++) out_d[l].valid = 1'b0;
    end else if (fire) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        out_d[l].valid = ~inv[l];
        out_d[l].wr    = w[l];
        out_d[l].prd   = tag[l];
      end
      out_d[0].prs1    = smt_rd[0];
      out_d[0].prs2    = smt_rd[1];
      out_d[0].old_prd = smt_rd[2];
      out_d[1].prs1    = byp_rs1 ? tag[0] : smt_rd[3];
      out_d[1].prs2    = byp_rs2 ? tag[0] : smt_rd[4];
      out_d[1].old_prd = byp_rd  ? tag[0] : smt_rd[5];
    end else if (!io.stall_DP) begin
      for (int l = 0; l < NUM_LANES; l++) out_d[l].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign io.rn_valid_1 = out_q[0].valid;
  assign io.rn_valid_2 = out_q[1].valid;
  assign io.rn_wr_1    = out_q[0].wr;
  assign io.rn_wr_2    = out_q[1].wr;
  assign io.prs1_1     = out_q[0].prs1;
  assign io.prs2_1     = out_q[0].prs2;
  assign io.prs1_2     = out_q[1].prs1;
  assign io.prs2_2     = out_q[1].prs2;
  assign io.prd_1      = out_q[0].prd;
  assign io.prd_2      = out_q[1].prd;
  assign io.old_prd_1  = out_q[0].old_prd;
  assign io.old_prd_2  = out_q[1].old_prd;
  assign io.rn_stall   = ~io.allocatable;
endmodule
